// File: rtl/fetch_prefetch_q.sv
// Prefetching fetch stage: issues req/ack reads into a DEPTH-entry FIFO and
// hands instructions to decode, with redirect/flush, in-flight squash and stall.
module fetch_prefetch_q #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ADDR_W   = 7,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(32'h40)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              is_if_stall,
    input  logic              id_if_selpcsource,
    input  logic [1:0]        id_if_selpctype,
    input  logic [XLEN-1:0]   id_if_rega,
    input  logic [XLEN-1:0]   id_if_pcimd2ext,
    input  logic [XLEN-1:0]   id_if_pcindex,
    output logic [XLEN-1:0]   if_id_instruc,
    output logic [XLEN-1:0]   if_id_nextpc,
    output logic              if_id_valid
);

    localparam int unsigned     PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] nextpc;
    } entry_t;

    state_t           state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_inc;
    entry_t           fifo [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic             redirect;
    logic             pop;
    logic             push;
    logic             issue;
    logic [XLEN-1:0]  target;

    assign pc_inc   = pc + XLEN'(1);
    assign redirect = !is_if_stall && id_if_selpcsource;
    assign pop      = !is_if_stall && !id_if_selpcsource && (count != '0);
    assign push     = (state == REQ) && mem_ack && !redirect;
    // Issue only when a slot is guaranteed free for the response.
    assign issue    = (state == IDLE) && !redirect && ((count != FULL) || pop);

    always_comb begin
        // NOTE: default assignment first so every path drives target; no latch is inferred.
        target = id_if_pcimd2ext;
        case (id_if_selpctype)
            2'b01:   target = id_if_rega;
            2'b10:   target = id_if_pcindex;
            2'b11:   target = TRAP_PC;
            default: target = id_if_pcimd2ext;
        endcase
    end

    // NOTE: FIFO storage has no reset; count and pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo[wr_ptr] <= '{instr: mem_rdata, nextpc: pc_inc};
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            if_id_instruc <= '0;
            if_id_nextpc  <= '0;
            if_id_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc[ADDR_W-1:0];
                    end
                end
                REQ: begin
                    // An ack coinciding with a redirect completes the request; its data is dropped.
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (redirect) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            if (redirect) begin
                pc <= target;
            end else if (push) begin
                pc <= pc_inc;
            end

            if (redirect) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end

            if (redirect) begin
                if_id_instruc <= '0;
                if_id_nextpc  <= target;
                if_id_valid   <= 1'b0;
            end else if (pop) begin
                if_id_instruc <= fifo[rd_ptr].instr;
                if_id_nextpc  <= fifo[rd_ptr].nextpc;
                if_id_valid   <= 1'b1;
            end else if (!is_if_stall) begin
                if_id_instruc <= '0;
                if_id_valid   <= 1'b0;
            end
        end
    end

endmodule
